// File: rtl/mem_access.sv
// Byte-serial load/store unit between the execute stage and an 8-bit synchronous RAM.
// Optional feature: define MEM_ACCESS_MISALIGN_CHECK_EN to reject misaligned half/word accesses.
module mem_access (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        load_in,
  input  logic        store_in,
  input  logic [1:0]  size_in,
  input  logic        unsigned_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        busy_out,
  output logic        done_out,
  output logic [31:0] rdata_out,
  output logic        err_out,
  output logic [31:0] mem_a_out,
  output logic [7:0]  mem_dout_out,
  output logic        mem_wr_out,
  input  logic [7:0]  mem_din_in
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      cnt;
  logic [2:0]      nbytes_q;
  logic [31:0]     addr_q;
  logic [3:0][7:0] wdata_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [3:0][7:0] buf_q, buf_nxt;
  logic [1:0]      rd_idx;
  logic            req;
  logic            misalign;

  function automatic logic [2:0] byte_count(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] sz,
                                         input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b = raw[7:0];
    h = raw[15:0];
    case (sz)
      2'd0: begin
        w = b;
        return uns ? {24'd0, raw[7:0]} : w;
      end
      2'd1: begin
        w = h;
        return uns ? {16'd0, raw[15:0]} : w;
      end
      default: return raw;
    endcase
  endfunction

  assign req = load_in | store_in;

`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
  logic err_q;

  assign misalign = ((size_in == 2'd1) && addr_in[0]) ||
                    (size_in[1] && (addr_in[1:0] != 2'd0));

  always_ff @(posedge clk_in) begin
    if (rst_in)
      err_q <= 1'b0;
    else if (state == IDLE && req)
      err_q <= misalign;
  end

  assign err_out = (state == DONE) && err_q;
`else
  assign misalign = 1'b0;
  assign err_out  = 1'b0;
`endif

  // Read byte arriving this cycle belongs to the address presented one cycle earlier.
  assign rd_idx = cnt[1:0] - 2'd1;

  always_comb begin
    buf_nxt = buf_q;
    if (cnt != 3'd0)
      buf_nxt[rd_idx] = mem_din_in;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      rdata_out <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        LOAD: begin
          cnt <= cnt + 3'd1;
          if (cnt == nbytes_q)
            rdata_out <= extend(buf_nxt, size_q, uns_q);
        end
        STORE:   cnt <= cnt + 3'd1;
        default: cnt <= 3'd0;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (state == IDLE && req) begin
      addr_q   <= addr_in;
      wdata_q  <= wdata_in;
      size_q   <= size_in;
      uns_q    <= unsigned_in;
      nbytes_q <= byte_count(size_in);
    end
    if (state == LOAD && cnt != 3'd0)
      buf_q <= buf_nxt;
  end

  always_comb begin
    state_nxt    = state;
    busy_out     = 1'b0;
    done_out     = 1'b0;
    mem_a_out    = 32'd0;
    mem_dout_out = 8'd0;
    mem_wr_out   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          busy_out = 1'b1;
          if (misalign)
            state_nxt = DONE;
          else if (load_in)
            state_nxt = LOAD;
          else
            state_nxt = STORE;
        end
      end
      LOAD: begin
        busy_out = 1'b1;
        if (cnt < nbytes_q)
          mem_a_out = addr_q + {29'd0, cnt};
        if (cnt == nbytes_q)
          state_nxt = DONE;
      end
      STORE: begin
        busy_out     = 1'b1;
        mem_a_out    = addr_q + {29'd0, cnt};
        mem_dout_out = wdata_q[cnt[1:0]];
        mem_wr_out   = 1'b1;
        if (cnt == nbytes_q - 3'd1)
          state_nxt = DONE;
      end
      DONE: begin
        done_out  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: byte RAM model plus transaction-level reference of expected bus activity.
// Honours MEM_ACCESS_MISALIGN_CHECK_EN the same way the design does.
module tb_mem_access;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        load_in, store_in, unsigned_in;
  logic [1:0]  size_in;
  logic [31:0] addr_in, wdata_in;
  logic        busy_out, done_out, err_out, mem_wr_out;
  logic [31:0] rdata_out, mem_a_out;
  logic [7:0]  mem_dout_out, mem_din_in;

  logic [7:0]  ram     [0:1023];
  logic [7:0]  ref_mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_a;
  logic [7:0]  pre_d;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rd;

  always #5 clk_in = ~clk_in;

  mem_access dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .load_in      (load_in),
    .store_in     (store_in),
    .size_in      (size_in),
    .unsigned_in  (unsigned_in),
    .addr_in      (addr_in),
    .wdata_in     (wdata_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .rdata_out    (rdata_out),
    .err_out      (err_out),
    .mem_a_out    (mem_a_out),
    .mem_dout_out (mem_dout_out),
    .mem_wr_out   (mem_wr_out),
    .mem_din_in   (mem_din_in)
  );

  // Synchronous byte RAM, aliased on the low 10 address bits.
  always_ff @(posedge clk_in) begin
    if (pre_we)
      ram[pre_a] <= pre_d;
    else if (mem_wr_out)
      ram[mem_a_out[9:0]] <= mem_dout_out;
    mem_din_in <= ram[mem_a_out[9:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic run_txn(input bit is_load, input logic [1:0] sz, input bit uns,
                         input logic [31:0] a, input logic [31:0] wd);
    int          n, dc, sh;
    bit          mis;
    logic [31:0] raw, ea, new_rd;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis = 1'b0;
`ifdef MEM_ACCESS_MISALIGN_CHECK_EN
    mis = (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'd0);
`endif
    dc = mis ? 1 : (is_load ? n + 2 : n + 1);
    new_rd = exp_rd;
    if (is_load && !mis) begin
      raw = 32'd0;
      for (int k = 0; k < n; k++) begin
        ea  = a + k;
        raw = raw | (32'(ref_mem[ea[9:0]]) << (8 * k));
      end
      sh = 32 - 8 * n;
      if (uns) new_rd = raw;
      else     new_rd = $signed(raw << sh) >>> sh;
    end
    load_in     = is_load;
    store_in    = is_load ? 1'($urandom % 2) : 1'b1;
    size_in     = sz;
    unsigned_in = uns;
    addr_in     = a;
    wdata_in    = wd;
    @(negedge clk_in);
    chk("req_busy", busy_out, 1);
    chk("req_done", done_out, 0);
    chk("idle_addr", mem_a_out, 0);
    chk("idle_wr", mem_wr_out, 0);
    chk("idle_rdata", rdata_out, exp_rd);
    for (int c = 1; c <= dc; c++) begin
      cyc();
      // a request held during the DONE cycle must not be taken
      load_in     = (c == dc);
      store_in    = 1'b0;
      addr_in     = $urandom;
      wdata_in    = $urandom;
      size_in     = 2'($urandom);
      unsigned_in = 1'($urandom);
      @(negedge clk_in);
      chk("done", done_out, (c == dc));
      chk("busy", busy_out, (c < dc));
      if (!mis && c <= n) begin
        ea = a + (c - 1);
        chk("addr", mem_a_out, ea);
        chk("wr", mem_wr_out, !is_load);
        if (!is_load) chk("dout", mem_dout_out, (wd >> (8 * (c - 1))) & 32'hFF);
      end else begin
        chk("wr_off", mem_wr_out, 0);
      end
      if (c == dc) begin
        chk("err", err_out, mis);
        exp_rd = new_rd;
        chk("rdata", rdata_out, exp_rd);
      end
    end
    cyc();
    load_in  = 1'b0;
    store_in = 1'b0;
    if (!is_load && !mis) begin
      for (int k = 0; k < n; k++) begin
        ea = a + k;
        ref_mem[ea[9:0]] = 8'((wd >> (8 * k)) & 32'hFF);
      end
    end
    for (int k = 0; k < n; k++) begin
      ea = a + k;
      chk("ram", ram[ea[9:0]], ref_mem[ea[9:0]]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra;
    rst_in = 1'b1; load_in = 1'b0; store_in = 1'b0; size_in = 2'd0; unsigned_in = 1'b0;
    addr_in = 32'd0; wdata_in = 32'd0; pre_we = 1'b0; pre_a = 10'd0; pre_d = 8'd0;
    exp_rd = 32'd0;

    // Fill RAM while held in reset; a few bytes are fixed for the directed loads.
    for (int i = 0; i < 1024; i++) begin
      pre_we = 1'b1;
      pre_a  = 10'(i);
      case (i)
        10'h100: pre_d = 8'h78;
        10'h101: pre_d = 8'h56;
        10'h102: pre_d = 8'h34;
        10'h103: pre_d = 8'h12;
        10'h005: pre_d = 8'h80;
        default: pre_d = 8'($urandom);
      endcase
      ref_mem[i] = pre_d;
      load_in  = 1'($urandom);
      store_in = 1'($urandom);
      cyc();
    end
    pre_we = 1'b0;
    load_in = 1'b0;
    store_in = 1'b0;
    @(negedge clk_in);
    chk("rst_busy", busy_out, 0);
    chk("rst_done", done_out, 0);
    chk("rst_rdata", rdata_out, 0);
    chk("rst_err", err_out, 0);
    chk("rst_addr", mem_a_out, 0);
    chk("rst_wr", mem_wr_out, 0);
    cyc();
    rst_in = 1'b0;

    run_txn(1, 2'd2, 0, 32'h100, 32'h0);
    chk("lw_val", rdata_out, 32'h12345678);
    run_txn(1, 2'd0, 0, 32'h5, 32'h0);
    chk("lb_val", rdata_out, 32'hFFFFFF80);
    run_txn(1, 2'd0, 1, 32'h5, 32'h0);
    chk("lbu_val", rdata_out, 32'h00000080);
    run_txn(0, 2'd1, 0, 32'h200, 32'hDEADBEEF);
    chk("sh_b0", ram[10'h200], 8'hEF);
    chk("sh_b1", ram[10'h201], 8'hBE);
    chk("sh_keep", rdata_out, 32'h00000080);
    run_txn(1, 2'd1, 0, 32'hFFFFFFFF, 32'h0);
    run_txn(1, 2'd3, 1, 32'h100, 32'h0);

    // Store aborted by reset on its second byte
    store_in = 1'b1; load_in = 1'b0; size_in = 2'd2; addr_in = 32'h300; wdata_in = 32'hA1B2C3D4;
    cyc();
    store_in = 1'b0; addr_in = $urandom;
    @(negedge clk_in);
    chk("ab_addr1", mem_a_out, 32'h300);
    chk("ab_wr1", mem_wr_out, 1);
    cyc();
    rst_in = 1'b1;
    @(negedge clk_in);
    chk("ab_addr2", mem_a_out, 32'h301);
    cyc();
    rst_in = 1'b0;
    ref_mem[10'h300] = 8'hD4;
    ref_mem[10'h301] = 8'hC3;
    exp_rd = 32'd0;
    @(negedge clk_in);
    chk("ab_wr3", mem_wr_out, 0);
    chk("ab_busy3", busy_out, 0);
    chk("ab_done3", done_out, 0);
    chk("ab_rdata3", rdata_out, 0);
    chk("ab_ram2", ram[10'h302], ref_mem[10'h302]);
    chk("ab_ram1", ram[10'h301], 8'hC3);
    cyc();
    run_txn(1, 2'd2, 0, 32'h300, 32'h0);

    for (int t = 0; t < 60; t++) begin
      ra = (t % 4 == 0) ? (32'hFFFFFFFC + 32'($urandom_range(0, 3))) : $urandom;
      run_txn(1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL clock on clk_in and reset on rst_in; reset is synchronous and active-high, single clock domain.
REQ-002 clk_in  input  1  system clock, all state updates on rising edge.
REQ-003 rst_in  input  1  synchronous active-high reset.
REQ-004 load_in  input  1  load request from execute stage.
REQ-005 store_in  input  1  store request from execute stage.
REQ-006 size_in  input  2  0=byte, 1=half, 2=word; 3 treated as word.
REQ-007 unsigned_in  input  1  1=zero-extend load, 0=sign-extend (LBU/LHU vs LB/LH).
REQ-008 addr_in  input  32  byte address of access.
REQ-009 wdata_in  input  32  store data, low bytes used.
REQ-010 busy_out  output  1  stall request to pipeline.
REQ-011 done_out  output  1  one-cycle completion pulse.
REQ-012 rdata_out  output  32  extended load result.
REQ-013 err_out  output  1  misaligned-access pulse (see Configuration).
REQ-014 mem_a_out  output  32  RAM byte address.
REQ-015 mem_dout_out  output  8  RAM write byte.
REQ-016 mem_wr_out  output  1  RAM write strobe, 1=write.
REQ-017 mem_din_in  input  8  RAM read byte, valid one cycle after mem_a_out presented.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD, STORE, DONE.
REQ-019 In IDLE, request accepted on edge where load_in or store_in is high; load_in wins if both high.
REQ-020 Byte count n = 1/2/4 for size 0/1/2(3); transfer order little-endian, byte k at addr_in+k modulo 2^32 (wrap from 0xFFFFFFFF to 0x00000000).
REQ-021 addr, wdata, size, unsigned captured at acceptance; inputs ignored in all non-IDLE states.
REQ-022 STORE: cycles 1..n after acceptance drive mem_a_out=addr+k-1, mem_dout_out=wdata byte k-1, mem_wr_out=1; then DONE.
REQ-023 LOAD: cycles 1..n drive mem_a_out=addr+k-1 with mem_wr_out=0; mem_din_in captured cycles 2..n+1 into byte k-1; then DONE.
REQ-024 DONE lasts one cycle: done_out=1, returns to IDLE; load done at cycle n+2, store done at cycle n+1 after acceptance.
REQ-025 rdata_out updated at load DONE entry with size/unsigned extension; holds until next load completes; stores do not change it.
REQ-026 busy_out = (state is LOAD or STORE) OR (state IDLE AND (load_in OR store_in)); low in DONE.
REQ-027 mem_wr_out SHALL be 0 in every state other than STORE; mem_a_out/mem_dout_out 0 when idle.
REQ-028 Back-to-back: request present in DONE cycle is not accepted; accepted in following IDLE cycle.

Reset
REQ-029 rst_in high on an edge SHALL force IDLE and clear all outputs to 0 (rdata_out=0, mem_wr_out=0) from the next cycle, aborting any transfer in progress; partially written bytes remain in RAM.
REQ-030 First request after rst_in deasserts accepted on the first edge with rst_in low.

Configuration
REQ-031 Macro MEM_ACCESS_MISALIGN_CHECK_EN defined: half at odd address or word with addr[1:0]!=0 SHALL perform no RAM access, go directly to DONE next cycle with done_out=1, err_out=1, rdata_out unchanged.
REQ-032 Macro undefined: misaligned accesses proceed byte-wise per REQ-020; err_out tied 0.

Verification
REQ-033 LW addr 0x100, RAM bytes 78,56,34,12 -> mem_a_out 0x100..0x103 cycles 1-4, done_out cycle 6, rdata_out=0x12345678.
REQ-034 LB addr 0x5 byte 0x80 -> rdata_out=0xFFFFFF80; LBU same -> 0x00000080; done cycle 3.
REQ-035 SH addr 0x200 wdata 0xDEADBEEF -> writes 0xEF@0x200, 0xBE@0x201, mem_wr_out high cycles 1-2 only, done cycle 3, rdata_out unchanged.
REQ-036 LH addr 0xFFFFFFFF (macro off) -> addresses 0xFFFFFFFF then 0x00000000; with macro on -> no mem access, err_out and done_out pulse cycle 1.
REQ-037 SW started, rst_in asserted at cycle 2 -> mem_wr_out 0 from cycle 3, busy_out 0, no done_out; new LW accepted after reset completes normally.
